char_seq_gen: RTL
=================

CHAR_SEQ_GEN -- requirements
Module: char_seq_gen

Interface
REQ-001 Parameter N_CHARS, default 5, number of characters in the sequence; legal range 2..16.
REQ-002 Parameter CHAR_W, default 8, character width in bits (ASCII).
REQ-003 CLK  input  1  clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 START  input  1  single-cycle request to begin a sequence.
REQ-006 STOP  input  1  abort the current sequence and return to IDLE.
REQ-007 DIR  input  1  0 = forward (index 0 to N_CHARS-1), 1 = reverse.
REQ-008 LOOP  input  1  1 = wrap continuously, 0 = one-shot.
REQ-009 OUT_RDY  input  1  consumer ready for the current character.
REQ-010 WR_EN  input  1  character-table write strobe.
REQ-011 WR_ADDR  input  4  character-table write index.
REQ-012 WR_DATA  input  CHAR_W  character-table write data.
REQ-013 CHAR  output  CHAR_W  current character.
REQ-014 VALID  output  1  CHAR is valid for transfer.
REQ-015 IDX  output  N_CHARS  one-hot ring position of the current character.
REQ-016 DONE  output  1  one-shot sequence complete.
REQ-017 LAP_CNT  output  8  count of completed wraps in LOOP mode.

Function
REQ-018 Sequencing SHALL use an N_CHARS-bit one-hot ring register (IDX), rotated one position per advance.
REQ-019 The character table SHALL be N_CHARS registers of CHAR_W bits; CHAR SHALL equal table[position of the set bit in IDX], read combinationally from registers.
REQ-020 The FSM SHALL have exactly three states: IDLE, RUN and FIN.
REQ-021 IDLE: VALID=0, DONE=0; START moves to RUN, loading IDX to bit 0 if DIR=0 or bit N_CHARS-1 if DIR=1.
REQ-022 RUN: VALID=1; an advance occurs on a cycle where VALID=1 and OUT_RDY=1; with OUT_RDY=0, IDX and CHAR SHALL hold.
REQ-023 Advance direction SHALL be DIR as sampled on the advancing cycle; the terminal position is bit N_CHARS-1 for DIR=0 and bit 0 for DIR=1.
REQ-024 Advance from a non-terminal position SHALL move IDX one position in direction DIR.
REQ-025 Advance from the terminal position with LOOP=1 SHALL wrap IDX to the start position for DIR, stay in RUN, and increment LAP_CNT modulo 256.
REQ-026 Advance from the terminal position with LOOP=0 SHALL enter FIN with IDX unchanged.
REQ-027 FIN: VALID=0, DONE=1; START re-enters RUN exactly as from IDLE and clears DONE the same cycle VALID rises.
REQ-028 START while in RUN SHALL be ignored.
REQ-029 STOP in RUN or FIN SHALL enter IDLE on the next edge and SHALL take priority over START and over an advance in the same cycle.
REQ-030 A write (WR_EN=1) with WR_ADDR < N_CHARS SHALL update that entry on the clock edge, in any state; CHAR SHALL reflect it the following cycle if it is the current entry.
REQ-031 Writes with WR_ADDR >= N_CHARS SHALL be ignored.
REQ-032 LAP_CNT SHALL clear on every START accepted from IDLE or FIN.
REQ-033 Latency from START to VALID=1 SHALL be one clock.

Reset
REQ-034 While RST_N=0: state=IDLE, IDX=one-hot bit 0, VALID=0, DONE=0, LAP_CNT=0, table[i]=8'h41+i ('A'+i), all without a clock edge.
REQ-035 Reset asserted mid-sequence SHALL abort immediately; the first START after release SHALL behave as from IDLE.

Verification
REQ-036 Default table, DIR=0, LOOP=0, OUT_RDY=1, pulse START -> CHAR 'A','B','C','D','E' on 5 consecutive VALID cycles, then DONE=1, VALID=0.
REQ-037 DIR=1, LOOP=1, OUT_RDY=1 for 12 transfers -> 'E','D','C','B','A','E',...; LAP_CNT=2 after the 10th transfer.
REQ-038 OUT_RDY toggles 1,0,0,1 during RUN -> CHAR holds 'B' through both stalled cycles, then advances to 'C'.
REQ-039 Write 8'h52 ('R') to addr 0 and 8'h5A to addr 7 (N_CHARS=5) before START -> first CHAR 'R'; table entries 1..4 unchanged.
REQ-040 START and STOP asserted together during RUN -> IDLE, VALID=0 next cycle; RST_N low mid-RUN -> VALID=0, IDX=5'b00001 asynchronously.
REQ-041 Repeat REQ-036 with N_CHARS=2 and N_CHARS=16 -> sequence length equals N_CHARS and wraps correctly.

Source files
------------

// File: rtl/char_seq_gen_if.sv
// Handshake and table-write bundle for char_seq_gen.
// The master modport drives control and table writes; the slave modport is the generator.
interface char_seq_gen_if #(
    parameter int N_CHARS = 5,
    parameter int CHAR_W  = 8
);
    logic                start;
    logic                stop;
    logic                dir;
    logic                loop;
    logic                out_rdy;
    logic                wr_en;
    logic [3:0]          wr_addr;
    logic [CHAR_W-1:0]   wr_data;
    logic [CHAR_W-1:0]   char;
    logic                valid;
    logic [N_CHARS-1:0]  idx;
    logic                done;
    logic [7:0]          lap_cnt;

    modport master (
        output start, stop, dir, loop, out_rdy, wr_en, wr_addr, wr_data,
        input  char, valid, idx, done, lap_cnt
    );

    modport slave (
        input  start, stop, dir, loop, out_rdy, wr_en, wr_addr, wr_data,
        output char, valid, idx, done, lap_cnt
    );
endinterface

// File: rtl/char_seq_gen.sv
// Character sequence generator: a one-hot ring walks a writable character table
// forward or backward, one-shot or looping, with a valid/ready output handshake.
module char_seq_gen #(
    parameter int N_CHARS = 5,
    parameter int CHAR_W  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    char_seq_gen_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [N_CHARS-1:0]  idx_q, idx_d;
    logic [7:0]          lap_q, lap_d;
    logic [CHAR_W-1:0]   table_q [N_CHARS];
    logic [CHAR_W-1:0]   table_d [N_CHARS];

    logic [N_CHARS-1:0]  first_pos;
    logic [CHAR_W-1:0]   char_mux;
    logic                terminal;

    always_comb begin
        first_pos = '0;
        if (bus.dir) first_pos[N_CHARS-1] = 1'b1;
        else         first_pos[0]         = 1'b1;
    end

    assign terminal = bus.dir ? idx_q[0] : idx_q[N_CHARS-1];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lap_d   = lap_q;
        case (state_q)
            IDLE, FIN: begin
                if (state_q == FIN && bus.stop) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    state_d = RUN;
                    idx_d   = first_pos;
                    lap_d   = '0;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.out_rdy) begin
                    if (terminal) begin
                        if (bus.loop) begin
                            idx_d = first_pos;
                            lap_d = lap_q + 8'd1;
                        end else begin
                            state_d = FIN;
                        end
                    end else if (bus.dir) begin
                        idx_d = {idx_q[0], idx_q[N_CHARS-1:1]};
                    end else begin
                        idx_d = {idx_q[N_CHARS-2:0], idx_q[N_CHARS-1]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Matching each slot against the address filters out-of-range writes naturally.
    always_comb begin
        table_d = table_q;
        for (int unsigned i = 0; i < N_CHARS; i++) begin
            if (bus.wr_en && bus.wr_addr == 4'(i)) table_d[i] = bus.wr_data;
        end
    end

    always_comb begin
        char_mux = '0;
        for (int unsigned i = 0; i < N_CHARS; i++) begin
            if (idx_q[i]) char_mux = char_mux | table_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= N_CHARS'(1);
            lap_q   <= '0;
            for (int unsigned i = 0; i < N_CHARS; i++) begin
                table_q[i] <= CHAR_W'(32'h41 + i);
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lap_q   <= lap_d;
            table_q <= table_d;
        end
    end

    assign bus.char    = char_mux;
    assign bus.valid   = (state_q == RUN);
    assign bus.done    = (state_q == FIN);
    assign bus.idx     = idx_q;
    assign bus.lap_cnt = lap_q;
endmodule
